// File: rtl/fb_pkg.sv
// fb_pkg: palette colours and frame-writer state encoding shared by the
// frame-buffer write path.
package fb_pkg;

   typedef enum logic [3:0] {
      PAL_BLACK,
      PAL_WHITE,
      PAL_RED,
      PAL_GREEN,
      PAL_BLUE,
      PAL_YELLOW,
      PAL_CYAN,
      PAL_MAGENTA,
      PAL_GREY,
      PAL_ORANGE
   } palette_t;

   typedef enum logic [1:0] {IDLE, CLEAR, DRAW, WAIT_SWAP} fb_state_t;

endpackage

// File: rtl/fb_addr_pipe.sv
// fb_addr_pipe: two-stage pixel scale, range check and frame-buffer address
// pipeline; out-of-range beats fall out silently.
module fb_addr_pipe #(
   parameter int PIXEL_WIDTH = 1280,
   parameter int PIXEL_HEIGHT = 720,
   parameter int FB_SCALE = 4,
   localparam int HW = $clog2(PIXEL_WIDTH),
   localparam int VW = $clog2(PIXEL_HEIGHT),
   localparam int SH = $clog2(FB_SCALE),
   localparam int FB_WIDTH = PIXEL_WIDTH / FB_SCALE,
   localparam int FB_HEIGHT = PIXEL_HEIGHT / FB_SCALE,
   localparam int AW = $clog2(FB_WIDTH * FB_HEIGHT)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          valid_in,
   input  logic          buf_in,
   input  logic [HW-1:0] hcount_in,
   input  logic [VW-1:0] vcount_in,
   input  logic [3:0]    color_in,
   output logic          wr_out,
   output logic [AW:0]   addr_out,
   output logic [3:0]    data_out
);

   logic [HW-1:0] fx, s1_fx;
   logic [VW-1:0] fy, s1_fy;
   logic          s1_ok, s1_buf;
   logic [3:0]    s1_color;

   assign fx = hcount_in >> SH;
   assign fy = vcount_in >> SH;

   // The buffer bit travels with the beat so a swap cannot redirect it.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_ok    <= 1'b0;
         s1_buf   <= 1'b0;
         s1_fx    <= '0;
         s1_fy    <= '0;
         s1_color <= 4'h0;
         wr_out   <= 1'b0;
         addr_out <= '0;
         data_out <= 4'h0;
      end else begin
         s1_ok    <= valid_in && 32'(fx) < FB_WIDTH && 32'(fy) < FB_HEIGHT;
         s1_buf   <= buf_in;
         s1_fx    <= fx;
         s1_fy    <= fy;
         s1_color <= color_in;
         wr_out   <= s1_ok;
         addr_out <= {s1_buf, AW'(32'(s1_fy) * FB_WIDTH + 32'(s1_fx))};
         data_out <= s1_color;
      end
   end

endmodule

// File: rtl/polygon_frame_writer.sv
// polygon_frame_writer: clears the back buffer, writes rasterised pixels into
// it and swaps front/back at the first vsync after the frame is complete.
module polygon_frame_writer import fb_pkg::*; #(
   parameter int          PIXEL_WIDTH = 1280,
   parameter int          PIXEL_HEIGHT = 720,
   parameter int          FB_SCALE = 4,
   parameter logic [3:0]  BG_COLOR = 4'(PAL_BLACK),
   localparam int         FB_WIDTH = PIXEL_WIDTH / FB_SCALE,
   localparam int         FB_HEIGHT = PIXEL_HEIGHT / FB_SCALE,
   localparam int         DEPTH = FB_WIDTH * FB_HEIGHT,
   localparam int         AW = $clog2(DEPTH)
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            frame_start_in,
   input  logic                            frame_end_in,
   input  logic                            vsync_in,
   input  logic [$clog2(PIXEL_WIDTH)-1:0]  hcount_in,
   input  logic [$clog2(PIXEL_HEIGHT)-1:0] vcount_in,
   input  logic [3:0]                      pixel_color_in,
   input  logic                            valid_in,
   input  logic                            done_in,
   output logic                            ready_out,
   output logic [AW:0]                     wr_addr_out,
   output logic [3:0]                      wr_data_out,
   output logic                            wr_en_out,
   output logic                            front_buf_out,
   output logic                            frame_done_out,
   output logic [7:0]                      poly_count_out,
   output logic                            drop_err_out
);

   fb_state_t     state, state_nxt;
   logic [AW-1:0] clr_cnt;
   logic          clear_wr, swap;
   logic          pipe_wr;
   logic [AW:0]   pipe_addr;
   logic [3:0]    pipe_data;

   fb_addr_pipe #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .PIXEL_HEIGHT(PIXEL_HEIGHT),
      .FB_SCALE    (FB_SCALE)
   ) u_pipe (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .valid_in (valid_in && state == DRAW),
      .buf_in   (~front_buf_out),
      .hcount_in(hcount_in),
      .vcount_in(vcount_in),
      .color_in (pixel_color_in),
      .wr_out   (pipe_wr),
      .addr_out (pipe_addr),
      .data_out (pipe_data)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = frame_start_in ? CLEAR : IDLE;
         CLEAR:     state_nxt = clr_cnt == AW'(DEPTH - 1) ? DRAW : CLEAR;
         DRAW:      state_nxt = frame_end_in ? WAIT_SWAP : DRAW;
         WAIT_SWAP: state_nxt = vsync_in ? IDLE : WAIT_SWAP;
         default:   state_nxt = IDLE;
      endcase
   end

   assign swap      = state == WAIT_SWAP && vsync_in;
   assign clear_wr  = state == CLEAR;
   assign ready_out = state == DRAW;

   // Pipeline writes win; they never overlap a clear when drawing is well formed.
   always_comb begin
      wr_en_out   = pipe_wr || clear_wr;
      wr_addr_out = pipe_wr ? pipe_addr : clear_wr ? {~front_buf_out, clr_cnt} : '0;
      wr_data_out = pipe_wr ? pipe_data : clear_wr ? BG_COLOR : 4'h0;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= IDLE;
         clr_cnt        <= '0;
         front_buf_out  <= 1'b0;
         frame_done_out <= 1'b0;
         poly_count_out <= 8'd0;
         drop_err_out   <= 1'b0;
      end else begin
         state          <= state_nxt;
         clr_cnt        <= clear_wr ? clr_cnt + 1'b1 : '0;
         front_buf_out  <= front_buf_out ^ swap;
         frame_done_out <= swap;
         drop_err_out   <= drop_err_out || (valid_in && state != DRAW);
         if (state == IDLE && frame_start_in)
            poly_count_out <= 8'd0;
         else if (state == DRAW && done_in && poly_count_out != 8'hff)
            poly_count_out <= poly_count_out + 8'd1;
      end
   end

endmodule
